// File: rtl/rc5_key_sched.sv
// -----------------------------------------------------------------------------
// rc5_key_sched
//
// Key-expansion controller for an RC5-16 core (w=16, c=8 key words, up to
// MAX_ROUNDS rounds). A start request in IDLE latches the key and the clamped
// round count. The subkey table S[0..t-1] (t = 2r+2) is then filled with the
// magic-constant progression, one entry per cycle. After that, 3*max(t,8)
// mixing iterations run, one per cycle. The finished table is held and served
// through a combinational read port.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (clears all state and tables)
//   start       expansion request, honoured only in IDLE
//   num_rounds  round count r; values above MAX_ROUNDS are clamped
//   key         128-bit user key, 16-bit word k = key[16k+15:16k]
//   busy        high from the cycle after acceptance through the done cycle
//   done        one-cycle completion pulse
//   key_valid   table complete and matching the last accepted key
//   sk_raddr    subkey read address
//   sk_rdata    S[sk_raddr] when sk_raddr < t, else 0 (combinational)
// -----------------------------------------------------------------------------
module rc5_key_sched #(
    parameter int          MAX_ROUNDS = 16,
    parameter logic [15:0] P16        = 16'hB7E1,
    parameter logic [15:0] Q16        = 16'h9E37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   num_rounds,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    input  logic [5:0]   sk_raddr,
    output logic [15:0]  sk_rdata
);

    localparam int         DEPTH   = 2 * MAX_ROUNDS + 2;
    localparam int         C_WORDS = 8;
    localparam logic [4:0] R_MAX   = 5'(MAX_ROUNDS);

    typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_t;

    // Rotate left by the low 4 bits; the upper half of {x,x} << amt is the
    // rotated word, and amt = 0 naturally returns x.
    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] amt);
        logic [31:0] dbl;
        dbl = {x, x} << amt;
        return dbl[31:16];
    endfunction

    state_t      state;
    logic [15:0] s_tab [DEPTH];
    logic [15:0] l_tab [C_WORDS];
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [5:0]  i_idx;
    logic [2:0]  j_idx;
    logic [5:0]  idx;
    logic [5:0]  t_reg;
    logic [6:0]  n_left;
    logic [15:0] init_val;

    // Table size and iteration count derived from the requested rounds.
    logic [4:0] r_eff;
    logic [5:0] t_new;
    logic [5:0] t_floor;
    logic [6:0] n_new;

    always_comb begin
        r_eff   = (num_rounds > R_MAX) ? R_MAX : num_rounds;
        t_new   = {r_eff, 1'b0} + 6'd2;
        t_floor = (t_new < 6'd8) ? 6'd8 : t_new;
        n_new   = {1'b0, t_floor} + {t_floor, 1'b0};   // 3 * max(t, 8)
    end

    // One mixing iteration: new A feeds the B computation in the same cycle.
    logic [15:0] s_cur;
    logic [15:0] l_cur;
    logic [15:0] a_new;
    logic [15:0] ab_sum;
    logic [15:0] b_new;

    always_comb begin
        s_cur  = s_tab[i_idx];
        l_cur  = l_tab[j_idx];
        a_new  = rotl16(s_cur + a_reg + b_reg, 4'd3);
        ab_sum = a_new + b_reg;
        b_new  = rotl16(l_cur + ab_sum, ab_sum[3:0]);
    end

    // Entries beyond the current table length read as zero even if they still
    // hold values from an earlier, longer schedule.
    always_comb begin
        sk_rdata = '0;
        if (sk_raddr < t_reg) begin
            sk_rdata = s_tab[sk_raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            idx       <= '0;
            t_reg     <= '0;
            n_left    <= '0;
            init_val  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                s_tab[k] <= '0;
            end
            for (int k = 0; k < C_WORDS; k++) begin
                l_tab[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        t_reg     <= t_new;
                        n_left    <= n_new;
                        for (int k = 0; k < C_WORDS; k++) begin
                            l_tab[k] <= key[16*k +: 16];
                        end
                        a_reg     <= '0;
                        b_reg     <= '0;
                        i_idx     <= '0;
                        j_idx     <= '0;
                        idx       <= '0;
                        init_val  <= P16;
                        key_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= INIT;
                    end
                end

                INIT: begin
                    // init_val tracks P16 + idx*Q16 incrementally.
                    s_tab[idx] <= init_val;
                    init_val   <= init_val + Q16;
                    if (idx == t_reg - 6'd1) begin
                        idx   <= '0;
                        i_idx <= '0;
                        j_idx <= '0;
                        state <= MIX;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end

                MIX: begin
                    s_tab[i_idx] <= a_new;
                    l_tab[j_idx] <= b_new;
                    a_reg        <= a_new;
                    b_reg        <= b_new;
                    i_idx        <= (i_idx == t_reg - 6'd1) ? 6'd0 : i_idx + 6'd1;
                    j_idx        <= j_idx + 3'd1;   // c = 8, wraps naturally
                    n_left       <= n_left - 7'd1;
                    if (n_left == 7'd1) begin
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_sched.sv
// -----------------------------------------------------------------------------
// tb_rc5_key_sched
//
// Self-checking bench for rc5_key_sched. A behavioural RC5-16 key-expansion
// model, written as the plain reference loop, predicts each table. A cycle
// timeline derived from the documented latency t + 3*max(t,8) + 1 predicts
// busy, done and key_valid. A negedge process compares the outputs every cycle.
// -----------------------------------------------------------------------------
module tb_rc5_key_sched;

    typedef logic [15:0] tab_t [34];
    typedef logic [15:0] rb_t  [64];

    logic         clk        = 1'b0;
    logic         rst        = 1'b0;
    logic         start      = 1'b0;
    logic [4:0]   num_rounds = '0;
    logic [127:0] key        = '0;
    logic [5:0]   sk_raddr   = '0;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [15:0]  sk_rdata;

    int total = 0;
    int bad   = 0;

    // Expected-behaviour bookkeeping
    bit          active   = 1'b0;
    int          cyc      = 0;
    int          lat      = 0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_kv   = 1'b0;
    int          exp_t    = 0;
    tab_t        exp_s;
    tab_t        pend_s;
    int          pend_t   = 0;
    logic [15:0] cmp_want;

    always #5 clk = ~clk;

    rc5_key_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_rounds (num_rounds),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .key_valid  (key_valid),
        .sk_raddr   (sk_raddr),
        .sk_rdata   (sk_rdata)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] x, input int amt);
        int          a;
        logic [15:0] lo;
        logic [15:0] hi;
        a = amt % 16;
        if (a == 0) return x;
        lo = x << a;
        hi = x >> (16 - a);
        return lo | hi;
    endfunction

    // Reference RC5-16 key expansion; max_iter < 0 runs the full schedule.
    task automatic model_expand(input logic [127:0] k, input int rounds, input int max_iter,
                                output tab_t s, output int t);
        logic [15:0] L [8];
        logic [15:0] A;
        logic [15:0] B;
        logic [15:0] sum;
        logic [31:0] wide;
        int          r;
        int          n;
        int          i;
        int          j;
        r = (rounds > 16) ? 16 : rounds;
        t = 2 * r + 2;
        for (int m = 0; m < 8; m++) L[m] = k[16*m +: 16];
        for (int x = 0; x < 34; x++) s[x] = '0;
        for (int x = 0; x < t; x++) begin
            wide = 32'hB7E1 + 32'(x) * 32'h9E37;
            s[x] = wide[15:0];
        end
        n = 3 * ((t > 8) ? t : 8);
        if (max_iter >= 0 && max_iter < n) n = max_iter;
        A = '0; B = '0; i = 0; j = 0;
        for (int it = 0; it < n; it++) begin
            sum  = s[i] + A + B;
            A    = rotl(sum, 3);
            s[i] = A;
            sum  = A + B;
            B    = rotl(L[j] + sum, int'(sum));
            L[j] = B;
            i = (i + 1) % t;
            j = (j + 1) % 8;
        end
    endtask

    function automatic int spec_latency(input int r);
        int rr;
        int t;
        rr = (r > 16) ? 16 : r;
        t  = 2 * rr + 2;
        return t + 3 * ((t > 8) ? t : 8) + 1;
    endfunction

    task automatic clear_expect();
        active   = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_kv   = 1'b0;
        exp_t    = 0;
        for (int x = 0; x < 34; x++) exp_s[x] = '0;
    endtask

    // Advance one clock; update the expected timeline, including acceptance.
    task automatic step();
        bit           acc;
        logic [127:0] k_s;
        int           r_s;
        acc = (start === 1'b1) && !active && (rst === 1'b0);
        k_s = key;
        r_s = int'(num_rounds);
        @(posedge clk);
        #1;
        if (active) begin
            cyc++;
            if (cyc == lat) begin
                exp_done = 1'b1;
                exp_kv   = 1'b1;
                exp_t    = pend_t;
                exp_s    = pend_s;
            end else if (cyc == lat + 1) begin
                exp_done = 1'b0;
                exp_busy = 1'b0;
                active   = 1'b0;
            end
        end
        if (acc) begin
            model_expand(k_s, r_s, -1, pend_s, pend_t);
            lat      = spec_latency(r_s);
            active   = 1'b1;
            cyc      = 1;
            exp_busy = 1'b1;
            exp_done = 1'b0;
            exp_kv   = 1'b0;
        end
        sk_raddr = 6'($urandom_range(0, 63));
    endtask

    // Per-cycle compare of all outputs against the expected timeline/table.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("key_valid", 32'(key_valid), 32'(exp_kv));
        if (!exp_busy) begin
            cmp_want = '0;
            if (int'(sk_raddr) < exp_t) cmp_want = exp_s[sk_raddr];
            chk("sk_rdata", 32'(sk_rdata), 32'(cmp_want));
        end
    end

    task automatic check_table(input string tag, output rb_t got);
        logic [15:0] want;
        for (int a = 0; a < 64; a++) begin
            sk_raddr = 6'(a);
            #1;
            got[a] = sk_rdata;
            want = '0;
            if (a < exp_t) want = exp_s[a];
            chk($sformatf("%s_rd%0d", tag, a), 32'(got[a]), 32'(want));
        end
    endtask

    task automatic same_table(input string tag, input rb_t x, input rb_t y);
        for (int a = 0; a < 64; a++) begin
            chk($sformatf("%s_eq%0d", tag, a), 32'(x[a]), 32'(y[a]));
        end
    endtask

    task automatic run(input logic [127:0] k, input logic [4:0] r, input int want_lat,
                       input int poke_at, input int rst_at, input string tag);
        int          cnt;
        bit          seen;
        int          limit;
        logic [31:0] got_lat;
        limit = (rst_at > 0) ? 200 : want_lat + 20;
        key = k;
        num_rounds = r;
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = 1;
        seen = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        while (cnt < limit) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (cnt == poke_at) begin
                key        = {$urandom(), $urandom(), $urandom(), $urandom()};
                num_rounds = 5'($urandom_range(0, 31));
                start      = 1'b1;
            end
            if (cnt == rst_at) begin
                rst = 1'b1;
                #1;
                clear_expect();
            end
            step();
            cnt++;
            rst   = 1'b0;
            start = 1'b0;
        end
        if (rst_at > 0) begin
            chk({tag, "_no_done"}, 32'(seen), 32'd0);
            chk({tag, "_kv_low"}, 32'(key_valid), 32'd0);
        end else begin
            got_lat = seen ? 32'(cnt) : 32'hFFFF_FFFF;
            chk({tag, "_latency"}, got_lat, 32'(want_lat));
            if (seen) begin
                chk({tag, "_kv_at_done"}, 32'(key_valid), 32'd1);
                step();
                chk({tag, "_idle_after"}, 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab_t         ms;
        int           mt;
        rb_t          rb;
        rb_t          saved16;
        logic [127:0] k16;
        logic [127:0] kr;
        int           rr;

        for (int x = 0; x < 34; x++) begin
            exp_s[x]  = '0;
            pend_s[x] = '0;
        end
        #1 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        check_table("reset_idle", rb);

        // Hand-computed pins for the reference model
        chk("pin_rotl_a", 32'(rotl(16'h8001, 1)), 32'h0003);
        chk("pin_rotl_b", 32'(rotl(16'h1234, 4)), 32'h2341);
        chk("pin_rotl_c", 32'(rotl(16'h1234, 16)), 32'h1234);
        model_expand(128'h0, 1, 0, ms, mt);
        chk("pin_t_r1", 32'(mt), 32'd4);
        chk("pin_init0", 32'(ms[0]), 32'hB7E1);
        chk("pin_init1", 32'(ms[1]), 32'h5618);
        chk("pin_init2", 32'(ms[2]), 32'hF44F);
        chk("pin_init3", 32'(ms[3]), 32'h9286);
        chk("pin_init4", 32'(ms[4]), 32'h0000);
        model_expand(128'h0, 0, 1, ms, mt);
        chk("pin_mix1_s0", 32'(ms[0]), 32'hBF0D);
        model_expand(128'h0, 0, 2, ms, mt);
        chk("pin_mix2_s0", 32'(ms[0]), 32'hBF0D);
        chk("pin_mix2_s1", 32'(ms[1]), 32'h6836);

        // Latency and table, zero key, r=12
        run(128'h0, 5'd12, 105, -1, -1, "r12_zero");
        check_table("r12_zero", rb);

        // Round extremes
        run({$urandom(), $urandom(), $urandom(), $urandom()}, 5'd0, 27, -1, -1, "r0");
        check_table("r0", rb);
        k16 = {$urandom(), $urandom(), $urandom(), $urandom()};
        run(k16, 5'd16, 137, -1, -1, "r16");
        check_table("r16", saved16);
        run(k16, 5'd31, 137, -1, -1, "r31");
        check_table("r31", rb);
        same_table("r31_vs_r16", rb, saved16);

        // Key/rounds changed and start pulsed mid-MIX: ignored
        run(128'h0F0E0D0C0B0A09080706050403020100, 5'd12, 105, 60, -1, "sampling");
        check_table("sampling", rb);

        // Reset in the middle of an r=16 run, then a clean restart
        run(k16, 5'd16, 0, -1, 40, "rst_mid");
        check_table("rst_mid", rb);
        run(k16, 5'd16, 137, -1, -1, "restart");
        check_table("restart", rb);
        same_table("restart_vs_r16", rb, saved16);

        // Back-to-back: r=12 then immediately r=4
        run({$urandom(), $urandom(), $urandom(), $urandom()}, 5'd12, 105, -1, -1, "b2b_first");
        run({$urandom(), $urandom(), $urandom(), $urandom()}, 5'd4, 41, -1, -1, "b2b_r4");
        check_table("b2b_r4", rb);

        // Randomized keys and round counts
        for (int n = 0; n < 6; n++) begin
            kr = {$urandom(), $urandom(), $urandom(), $urandom()};
            rr = $urandom_range(0, 31);
            run(kr, 5'(rr), spec_latency(rr), -1, -1, $sformatf("rand%0d", n));
            check_table($sformatf("rand%0d", n), rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
